song_recorder: RTL and testbench

//  Write-side counterpart of the auto-play path. Captures notes played live
//  (note code, octave, duration) into a song buffer packed in the same format
//  Lib supplies to the player: 4-bit notes, 4-bit durations in TICK units,
//  2-bit octaves, 0xF end marker. A recording can then be replayed like a

---
 rtl/song_recorder_if.sv | 28 ++
 rtl/song_recorder.sv | 151 +++++++++++++++
 tb/tb_song_recorder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/song_recorder_if.sv
// Live-capture interface for song_recorder: player-side controls in, packed song buffer out.
interface song_recorder_if #(
  parameter int unsigned SONG_LEN = 56
);
  logic                  start;
  logic                  stop;
  logic [3:0]            note_in;
  logic [1:0]            octave_in;
  logic [SONG_LEN*4-1:0] song_packed;
  logic [SONG_LEN*4-1:0] time_packed;
  logic [SONG_LEN*2-1:0] octave_packed;
  logic [7:0]            note_count;
  logic                  recording;
  logic                  done;
  logic                  full;

  // Driver side (keyboard / test stimulus)
  modport master (
    output start, stop, note_in, octave_in,
    input  song_packed, time_packed, octave_packed, note_count, recording, done, full
  );

  // Recorder side
  modport slave (
    input  start, stop, note_in, octave_in,
    output song_packed, time_packed, octave_packed, note_count, recording, done, full
  );
endinterface

// File: rtl/song_recorder.sv
// Captures live notes into a packed song buffer in the same layout the player consumes:
// 4-bit note, 4-bit duration in TICK units, 2-bit octave per slot, 0xF end marker.
module song_recorder #(
  parameter int unsigned SONG_LEN = 56,
  parameter int unsigned TICK     = 10000000
) (
  input logic            clk,
  input logic            reset,
  song_recorder_if.slave bus
);
  localparam int unsigned     TickW    = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK - 1);
  localparam logic [7:0]      LastSlot = 8'(SONG_LEN - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRec, StDone} state_e;

  state_e                state_q, state_d;
  logic [SONG_LEN*4-1:0] song_q, song_d;
  logic [SONG_LEN*4-1:0] time_q, time_d;
  logic [SONG_LEN*2-1:0] oct_q, oct_d;
  logic [7:0]            count_q, count_d;
  logic                  full_q, full_d;
  logic                  recording_q, recording_d;
  logic                  done_q, done_d;
  logic [3:0]            cur_note_q, cur_note_d;
  logic [1:0]            cur_oct_q, cur_oct_d;
  logic [3:0]            units_q, units_d;
  logic [TickW-1:0]      tick_q, tick_d;

  logic [3:0] note_eff;
  logic [1:0] oct_eff;
  logic       change;
  int         idx;

  // Codes 8..15 are rests; rests always carry octave 0 so octave wiggle never splits them
  assign note_eff = bus.note_in[3] ? 4'd0 : bus.note_in;
  assign oct_eff  = (note_eff == 4'd0) ? 2'd0 : bus.octave_in;
  assign change   = (note_eff != cur_note_q) ||
                    ((note_eff != 4'd0) && (bus.octave_in != cur_oct_q));

  // Next-state, buffer writes and duration counting
  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    time_d     = time_q;
    oct_d      = oct_q;
    count_d    = count_q;
    full_d     = full_q;
    cur_note_d = cur_note_q;
    cur_oct_d  = cur_oct_q;
    units_d    = units_q;
    tick_d     = tick_q;
    idx        = int'(count_q);

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          song_d  = '0;
          time_d  = '0;
          oct_d   = '0;
          count_d = '0;
          full_d  = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.stop) begin
          song_d[3:0] = 4'hF;
          state_d     = StDone;
        end else if (note_eff != 4'd0) begin
          cur_note_d = note_eff;
          cur_oct_d  = oct_eff;
          units_d    = 4'd1;
          tick_d     = '0;
          state_d    = StRec;
        end
      end
      StRec: begin
        if (tick_q == TickMax) begin
          tick_d = '0;
          if (units_q != 4'd15) units_d = units_q + 4'd1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        // stop wins over a simultaneous change: commit once, ignore the inputs
        if (bus.stop || change) begin
          song_d[idx*4 +: 4] = cur_note_q;
          time_d[idx*4 +: 4] = units_q;
          oct_d[idx*2 +: 2]  = cur_oct_q;
          count_d            = count_q + 8'd1;
          if (count_d == LastSlot) begin
            song_d[(SONG_LEN-1)*4 +: 4] = 4'hF;
            full_d                      = 1'b1;
            state_d                     = StDone;
          end else if (bus.stop) begin
            song_d[(idx+1)*4 +: 4] = 4'hF;
            state_d                = StDone;
          end else begin
            cur_note_d = note_eff;
            cur_oct_d  = oct_eff;
            units_d    = 4'd1;
            tick_d     = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    recording_d = (state_d == StWait) || (state_d == StRec);
    done_d      = (state_d == StDone);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      song_q      <= '0;
      time_q      <= '0;
      oct_q       <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      recording_q <= 1'b0;
      done_q      <= 1'b0;
      cur_note_q  <= '0;
      cur_oct_q   <= '0;
      units_q     <= '0;
      tick_q      <= '0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      time_q      <= time_d;
      oct_q       <= oct_d;
      count_q     <= count_d;
      full_q      <= full_d;
      recording_q <= recording_d;
      done_q      <= done_d;
      cur_note_q  <= cur_note_d;
      cur_oct_q   <= cur_oct_d;
      units_q     <= units_d;
      tick_q      <= tick_d;
    end
  end

  assign bus.song_packed   = song_q;
  assign bus.time_packed   = time_q;
  assign bus.octave_packed = oct_q;
  assign bus.note_count    = count_q;
  assign bus.recording     = recording_q;
  assign bus.done          = done_q;
  assign bus.full          = full_q;
endmodule

// File: tb/tb_song_recorder.sv
// Bench for song_recorder: directed scenarios plus random recordings against a segment model.
module tb_song_recorder;
  localparam int unsigned SONG_LEN = 8;
  localparam int unsigned TICK     = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  song_recorder_if #(.SONG_LEN(SONG_LEN)) bus ();

  song_recorder #(.SONG_LEN(SONG_LEN), .TICK(TICK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus as held segments (note, octave, cycles); model folds them into entries
  int seg_note[$], seg_oct[$], seg_len[$];
  int en_note[$], en_oct[$], en_len[$];

  logic [SONG_LEN*4-1:0] exp_song, exp_time;
  logic [SONG_LEN*2-1:0] exp_oct;
  int                    exp_count;
  logic                  exp_full;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_segs();
    seg_note.delete();
    seg_oct.delete();
    seg_len.delete();
  endtask

  task automatic add_seg(int n, int o, int l);
    seg_note.push_back(n);
    seg_oct.push_back(o);
    seg_len.push_back(l);
  endtask

  // Expected song: drop leading rests, merge runs that are not a change, round durations up
  task automatic build_model();
    int n, o, u, last;
    en_note.delete();
    en_oct.delete();
    en_len.delete();
    foreach (seg_note[i]) begin
      n = (seg_note[i] > 7) ? 0 : seg_note[i];
      o = (n == 0) ? 0 : seg_oct[i];
      last = en_note.size() - 1;
      if (en_note.size() == 0) begin
        if (n != 0) begin
          en_note.push_back(n); en_oct.push_back(o); en_len.push_back(seg_len[i]);
        end
      end else if (en_note[last] == n && en_oct[last] == o) begin
        en_len[last] += seg_len[i];
      end else begin
        en_note.push_back(n); en_oct.push_back(o); en_len.push_back(seg_len[i]);
      end
    end
    exp_full  = (en_note.size() >= SONG_LEN - 1);
    exp_count = exp_full ? SONG_LEN - 1 : en_note.size();
    exp_song  = '0;
    exp_time  = '0;
    exp_oct   = '0;
    for (int k = 0; k < exp_count; k++) begin
      u = (en_len[k] + TICK - 1) / TICK;
      if (u > 15) u = 15;
      exp_song[k*4 +: 4] = 4'(en_note[k]);
      exp_time[k*4 +: 4] = 4'(u);
      exp_oct[k*2 +: 2]  = 2'(en_oct[k]);
    end
    exp_song[exp_count*4 +: 4] = 4'hF;
  endtask

  task automatic check_result(string tag);
    check({tag, ":song"}, 64'(bus.song_packed), 64'(exp_song));
    check({tag, ":time"}, 64'(bus.time_packed), 64'(exp_time));
    check({tag, ":oct"}, 64'(bus.octave_packed), 64'(exp_oct));
    check({tag, ":count"}, 64'(bus.note_count), 64'(exp_count));
    check({tag, ":done"}, 64'(bus.done), 64'd1);
    check({tag, ":full"}, 64'(bus.full), 64'(exp_full));
    check({tag, ":rec_off"}, 64'(bus.recording), 64'd0);
  endtask

  // Start, play all segments, stop, then verify and confirm the buffer holds in DONE
  task automatic run_recording(string tag);
    build_model();
    bus.note_in = 4'd0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, ":rec_on"}, 64'(bus.recording), 64'd1);
    foreach (seg_note[i]) begin
      bus.note_in   = 4'(seg_note[i]);
      bus.octave_in = 2'(seg_oct[i]);
      repeat (seg_len[i]) tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_result(tag);
    bus.note_in   = 4'($urandom_range(1, 7));
    bus.octave_in = 2'($urandom_range(0, 3));
    repeat (3) tick();
    check({tag, ":hold"}, 64'(bus.song_packed), 64'(exp_song));
  endtask

  initial begin
    int nseg, r, n, last;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.note_in   = 4'd0;
    bus.octave_in = 2'd0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst:song", 64'(bus.song_packed), 64'd0);
    check("rst:count", 64'(bus.note_count), 64'd0);
    check("rst:flags", 64'({bus.recording, bus.done, bus.full}), 64'd0);

    // Basic: two notes, durations 10 and 4 cycles
    clear_segs();
    add_seg(3, 1, 10);
    add_seg(5, 2, 4);
    run_recording("basic");
    check("basic:slot0_time", 64'(bus.time_packed[3:0]), 64'd3);
    check("basic:slot2_end", 64'(bus.song_packed[11:8]), 64'hF);

    // Saturation: 70 cycles would be 18 units
    clear_segs();
    add_seg(1, 0, 70);
    run_recording("sat");
    check("sat:slot0_time", 64'(bus.time_packed[3:0]), 64'd15);

    // Leading rest dropped, inner rest kept with octave forced to 0
    clear_segs();
    add_seg(0, 0, 6);
    add_seg(2, 1, 4);
    add_seg(0, 3, 5);
    add_seg(4, 1, 4);
    run_recording("rests");

    // Full: eight distinct notes, then more input after the buffer closed
    clear_segs();
    for (int i = 0; i < 8; i++) add_seg((i % 7) + 1, i % 4, 4);
    add_seg(6, 2, 5);
    run_recording("full");

    // Same note, new octave splits; code 11 behaves as a rest
    clear_segs();
    add_seg(3, 1, 4);
    add_seg(3, 2, 4);
    add_seg(11, 2, 3);
    run_recording("octchg");

    // start and stop together: start wins, stop then ends an empty recording
    bus.start   = 1'b1;
    bus.stop    = 1'b1;
    bus.note_in = 4'd0;
    tick();
    bus.start = 1'b0;
    check("both:rec_on", 64'(bus.recording), 64'd1);
    check("both:not_done", 64'(bus.done), 64'd0);
    tick();
    bus.stop = 1'b0;
    check("both:song", 64'(bus.song_packed), 64'hF);
    check("both:count", 64'(bus.note_count), 64'd0);
    check("both:done", 64'(bus.done), 64'd1);

    // Reset mid-recording after one commit
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.note_in   = 4'd2;
    bus.octave_in = 2'd1;
    repeat (3) tick();
    bus.note_in = 4'd5;
    repeat (2) tick();
    check("midrst:pre_count", 64'(bus.note_count), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst:song", 64'(bus.song_packed), 64'd0);
    check("midrst:time", 64'(bus.time_packed), 64'd0);
    check("midrst:oct", 64'(bus.octave_packed), 64'd0);
    check("midrst:count", 64'(bus.note_count), 64'd0);
    check("midrst:flags", 64'({bus.recording, bus.done, bus.full}), 64'd0);
    tick();
    check("midrst:idle", 64'(bus.recording), 64'd0);

    // Random recordings
    for (int t = 0; t < 25; t++) begin
      clear_segs();
      nseg = $urandom_range(1, 10);
      for (int i = 0; i < nseg; i++) begin
        r = $urandom_range(0, 9);
        if (r < 2) n = 0;
        else if (r == 2) n = $urandom_range(8, 15);
        else if (r == 9 && i > 0) n = seg_note[i-1];
        else n = $urandom_range(1, 7);
        add_seg(n, $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? $urandom_range(30, 70) : $urandom_range(1, 12));
      end
      // Keep clear of a stop landing exactly on the last free slot
      build_model();
      if (en_note.size() == SONG_LEN - 1) begin
        last = en_note[en_note.size() - 1];
        add_seg((last % 7) + 1, 0, 2);
      end
      run_recording("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
